// File: rtl/uart_sequencer_if.sv
// CPU-side and FIFO-chip-side signal bundle for uart_sequencer.
// The sequencer takes the master view; the environment driving it takes the slave view.
interface uart_sequencer_if;
  logic       cpu_rd;
  logic       cpu_wr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       flag_di;
  logic       flag_do;
  logic       err_under;
  logic       err_over;
  logic       _rxf;
  logic       _txe;
  logic       _rd;
  logic       wr;
  logic [7:0] ft_din;
  logic [7:0] ft_dout;
  logic       ft_doe;

  modport master (
    input  cpu_rd, cpu_wr, cpu_wdata, _rxf, _txe, ft_din,
    output cpu_rdata, flag_di, flag_do, err_under, err_over, _rd, wr, ft_dout, ft_doe
  );

  modport slave (
    output cpu_rd, cpu_wr, cpu_wdata, _rxf, _txe, ft_din,
    input  cpu_rdata, flag_di, flag_do, err_under, err_over, _rd, wr, ft_dout, ft_doe
  );
endinterface

// File: rtl/uart_sequencer.sv
// Sequences reads and writes to an FT245-style FIFO chip with fixed strobe widths,
// a bus recovery gap, round-robin arbitration and single-byte CPU holding registers.
module uart_sequencer #(
  parameter int unsigned RD_PULSE = 3,
  parameter int unsigned WR_PULSE = 3,
  parameter int unsigned RECOVER  = 2
) (
  input logic              clk,
  input logic              _mr,
  uart_sequencer_if.master bus
);
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RD_STROBE = 2'd1,
    ST_WR_STROBE = 2'd2,
    ST_RECOVER   = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_t;

  localparam logic [3:0] RD_LOAD  = 4'(RD_PULSE - 32'd1);
  localparam logic [3:0] WR_LOAD  = 4'(WR_PULSE - 32'd1);
  localparam logic [3:0] REC_LOAD = 4'(RECOVER - 32'd1);

  logic [1:0] rxf_sync_r;
  logic [1:0] txe_sync_r;
  state_t     state_r;
  state_t     state_nxt_s;
  logic [3:0] cnt_r;
  logic [3:0] cnt_nxt_s;
  grant_t     last_grant_r;
  grant_t     last_grant_nxt_s;
  logic       rd_n_r;
  logic       rd_n_nxt_s;
  logic       wr_r;
  logic       wr_nxt_s;
  logic       doe_r;
  logic       doe_nxt_s;
  logic       capture_s;
  logic       tx_done_s;
  logic       flag_di_r;
  logic       flag_do_r;
  logic [7:0] rdata_r;
  logic [7:0] tx_buf_r;
  logic       err_under_r;
  logic       err_over_r;
  logic       rxf_s;
  logic       txe_s;
  logic       rd_req_s;
  logic       wr_req_s;

  assign rxf_s    = rxf_sync_r[1];
  assign txe_s    = txe_sync_r[1];
  assign rd_req_s = !rxf_s && !flag_di_r;
  assign wr_req_s = !txe_s && !flag_do_r;

  // Bring the asynchronous FIFO status pins into the clock domain.
  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr) begin
      rxf_sync_r <= 2'b11;
      txe_sync_r <= 2'b11;
    end else begin
      rxf_sync_r <= {rxf_sync_r[0], bus._rxf};
      txe_sync_r <= {txe_sync_r[0], bus._txe};
    end
  end

  // Bus FSM next state, strobe counter and registered strobe values.
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    last_grant_nxt_s = last_grant_r;
    capture_s        = 1'b0;
    tx_done_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rd_req_s && wr_req_s) begin
          if (last_grant_r == GRANT_WR) begin
            state_nxt_s      = ST_RD_STROBE;
            cnt_nxt_s        = RD_LOAD;
            last_grant_nxt_s = GRANT_RD;
          end else begin
            state_nxt_s      = ST_WR_STROBE;
            cnt_nxt_s        = WR_LOAD;
            last_grant_nxt_s = GRANT_WR;
          end
        end else if (rd_req_s) begin
          state_nxt_s = ST_RD_STROBE;
          cnt_nxt_s   = RD_LOAD;
        end else if (wr_req_s) begin
          state_nxt_s = ST_WR_STROBE;
          cnt_nxt_s   = WR_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD_STROBE: begin
        if (cnt_r == 4'd0) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_RECOVER;
          cnt_nxt_s   = REC_LOAD;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_WR_STROBE: begin
        if (cnt_r == 4'd0) begin
          tx_done_s   = 1'b1;
          state_nxt_s = ST_RECOVER;
          cnt_nxt_s   = REC_LOAD;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_RECOVER: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
    // Strobes are registered from the next state so the pins change with the state.
    rd_n_nxt_s = (state_nxt_s != ST_RD_STROBE);
    wr_nxt_s   = (state_nxt_s == ST_WR_STROBE);
    doe_nxt_s  = (state_nxt_s == ST_WR_STROBE);
  end

  // Bus FSM state, counter, arbitration history and strobe pins.
  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      last_grant_r <= GRANT_WR;
      rd_n_r       <= 1'b1;
      wr_r         <= 1'b0;
      doe_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      rd_n_r       <= rd_n_nxt_s;
      wr_r         <= wr_nxt_s;
      doe_r        <= doe_nxt_s;
    end
  end

  // CPU holding registers, availability flags and sticky misuse flags.
  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr) begin
      flag_di_r   <= 1'b0;
      flag_do_r   <= 1'b1;
      rdata_r     <= 8'h00;
      tx_buf_r    <= 8'h00;
      err_under_r <= 1'b0;
      err_over_r  <= 1'b0;
    end else begin
      if (capture_s) begin
        rdata_r   <= bus.ft_din;
        flag_di_r <= 1'b1;
      end else if (bus.cpu_rd && flag_di_r) begin
        flag_di_r <= 1'b0;
      end
      // A write strobe only runs while the buffer is full, so a CPU write then is an overrun.
      if (tx_done_s) begin
        flag_do_r <= 1'b1;
      end else if (bus.cpu_wr && flag_do_r) begin
        tx_buf_r  <= bus.cpu_wdata;
        flag_do_r <= 1'b0;
      end
      if (bus.cpu_rd && !flag_di_r) begin
        err_under_r <= 1'b1;
      end
      if (bus.cpu_wr && !flag_do_r) begin
        err_over_r <= 1'b1;
      end
    end
  end

  assign bus._rd       = rd_n_r;
  assign bus.wr        = wr_r;
  assign bus.ft_doe    = doe_r;
  assign bus.ft_dout   = tx_buf_r;
  assign bus.cpu_rdata = rdata_r;
  assign bus.flag_di   = flag_di_r;
  assign bus.flag_do   = flag_do_r;
  assign bus.err_under = err_under_r;
  assign bus.err_over  = err_over_r;
endmodule
